// File: rtl/n64_poll_sequencer.sv
// n64_poll_sequencer: drives the N64 command writer, then receives the
// controller reply on the shared data line and republishes it as a latched
// 32-bit button word. Polls repeat every POLL_PERIOD clocks while poll_en is high.
// Optional build macro N64_STATUS_PROBE_EN: after reset or a lost controller,
// a status command (8'h00) is sent first and its 24-bit reply validated.
module n64_poll_sequencer #(
    parameter int CLK_PER_BIT  = 400,
    parameter int SAMPLE_POINT = 200,
    parameter int RX_TIMEOUT   = 2000,
    parameter int POLL_PERIOD  = 1666666,
    parameter int BUSY_WAIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_en,
    output logic [7:0]  cmd_byte,
    output logic        cmd_en,
    input  logic        cmd_busy,
    input  logic        data_in,
    output logic [31:0] buttons,
    output logic        buttons_valid,
    output logic        ctrl_present
);

    // The shared counter times busy waits, sample points and edge timeouts;
    // a full bit cell must also fit so the width covers every use.
    localparam int CNT_M1  = (RX_TIMEOUT > CLK_PER_BIT) ? RX_TIMEOUT : CLK_PER_BIT;
    localparam int CNT_M2  = (CNT_M1 > SAMPLE_POINT) ? CNT_M1 : SAMPLE_POINT;
    localparam int CNT_MAX = (CNT_M2 > BUSY_WAIT) ? CNT_M2 : BUSY_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(POLL_PERIOD + 1);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_POINT - 1);
    localparam logic [CNT_W-1:0] RX_LAST     = CNT_W'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST   = CNT_W'(BUSY_WAIT - 1);
    localparam logic [PER_W-1:0] PER_LAST    = PER_W'(POLL_PERIOD - 1);

    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_STATUS = 8'h00;

    typedef enum logic [3:0] {
        IDLE, SEND, WAIT_BUSY, WAIT_DONE, RX_EDGE, RX_SAMPLE, RX_STOP, DONE, HOLDOFF
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [5:0]        bits_q, bits_d, last_bit;
    logic [PER_W-1:0]  period_q, period_d;
    logic [31:0]       shift_q, shift_d;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    logic              cmd_en_q, cmd_en_d;
    logic [31:0]       buttons_q, buttons_d;
    logic              valid_q, valid_d;
    logic              present_q, present_d;
    logic [2:0]        sync_q;
    logic              line, fall;

    // Two-flop synchroniser plus one history flop for falling-edge detection;
    // the idle line is high, so reset to ones to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], data_in};
        end
    end

    assign line    = sync_q[1];
    assign fall    = sync_q[2] & ~sync_q[1];
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef N64_STATUS_PROBE_EN
    assign last_bit = (cmd_byte_q == CMD_STATUS) ? 6'd23 : 6'd31;
`else
    assign last_bit = 6'd31;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bits_q     <= '0;
            period_q   <= '0;
            shift_q    <= '0;
            cmd_byte_q <= CMD_POLL;
            cmd_en_q   <= 1'b0;
            buttons_q  <= '0;
            valid_q    <= 1'b0;
            present_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            period_q   <= period_d;
            shift_q    <= shift_d;
            cmd_byte_q <= cmd_byte_d;
            cmd_en_q   <= cmd_en_d;
            buttons_q  <= buttons_d;
            valid_q    <= valid_d;
            present_q  <= present_d;
        end
    end

    // Next-state and next-output logic for the poll transaction
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bits_d     = bits_q;
        shift_d    = shift_q;
        period_d   = (period_q == PER_LAST) ? period_q : period_q + PER_W'(1);
        cmd_byte_d = cmd_byte_q;
        cmd_en_d   = 1'b0;
        buttons_d  = buttons_q;
        valid_d    = 1'b0;
        present_d  = present_q;

        case (state_q)
            IDLE: begin
                if (poll_en && !cmd_busy) state_d = SEND;
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (cmd_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= BUSY_LAST) begin
                    present_d = 1'b0;
                    state_d   = HOLDOFF;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                // The writer drives the line while busy; listening starts after.
                if (!cmd_busy) begin
                    cnt_d   = '0;
                    bits_d  = '0;
                    shift_d = '0;
                    state_d = RX_EDGE;
                end
            end
            RX_EDGE, RX_STOP: begin
                // Timeout runs from the previous edge, so cnt is not cleared here.
                if (fall) begin
                    cnt_d   = '0;
                    state_d = (state_q == RX_EDGE) ? RX_SAMPLE : DONE;
                end else if (cnt_q >= RX_LAST) begin
                    present_d = 1'b0;
                    state_d   = HOLDOFF;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RX_SAMPLE: begin
                cnt_d = cnt_inc;
                if (cnt_q >= SAMPLE_LAST) begin
                    shift_d = {shift_q[30:0], line};
                    bits_d  = bits_q + 6'd1;
                    state_d = (bits_q == last_bit) ? RX_STOP : RX_EDGE;
                end
            end
            DONE: begin
`ifdef N64_STATUS_PROBE_EN
                if (cmd_byte_q == CMD_STATUS) begin
                    if (shift_q[23:8] == 16'h0500) begin
                        present_d = 1'b1;
                        state_d   = cmd_busy ? HOLDOFF : SEND;
                    end else begin
                        present_d = 1'b0;
                        state_d   = HOLDOFF;
                    end
                end else begin
                    buttons_d = shift_q;
                    valid_d   = 1'b1;
                    present_d = 1'b1;
                    state_d   = HOLDOFF;
                end
`else
                buttons_d = shift_q;
                valid_d   = 1'b1;
                present_d = 1'b1;
                state_d   = HOLDOFF;
`endif
            end
            HOLDOFF: begin
                if (period_q == PER_LAST) begin
                    if (!poll_en)      state_d = IDLE;
                    else if (!cmd_busy) state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering SEND: one-cycle start pulse, fresh command byte, period restart.
        if (state_d == SEND && state_q != SEND) begin
            cmd_en_d = 1'b1;
            period_d = '0;
`ifdef N64_STATUS_PROBE_EN
            cmd_byte_d = present_d ? CMD_POLL : CMD_STATUS;
`else
            cmd_byte_d = CMD_POLL;
`endif
        end
    end

    assign cmd_byte      = cmd_byte_q;
    assign cmd_en        = cmd_en_q;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign ctrl_present  = present_q;

endmodule

// File: tb/tb_n64_poll_sequencer.sv
// Directed bench for n64_poll_sequencer with shortened timing parameters.
`timescale 1ns/1ps
module tb_n64_poll_sequencer;
    localparam int CPB    = 40;
    localparam int SP     = 20;
    localparam int RXT    = 200;
    localparam int PP     = 3000;
    localparam int BW     = 4;
    localparam int WR_CYC = 360;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        poll_en = 1'b0;
    logic        cmd_busy = 1'b0;
    logic        data_in = 1'b1;
    logic [7:0]  cmd_byte;
    logic        cmd_en;
    logic [31:0] buttons;
    logic        buttons_valid;
    logic        ctrl_present;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          vcnt = 0;
    int          en_cyc [0:63];
    logic [7:0]  last_byte = 8'hxx;
    bit          wr_ok = 1'b1;

    n64_poll_sequencer #(
        .CLK_PER_BIT (CPB),
        .SAMPLE_POINT(SP),
        .RX_TIMEOUT  (RXT),
        .POLL_PERIOD (PP),
        .BUSY_WAIT   (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .poll_en      (poll_en),
        .cmd_byte     (cmd_byte),
        .cmd_en       (cmd_en),
        .cmd_busy     (cmd_busy),
        .data_in      (data_in),
        .buttons      (buttons),
        .buttons_valid(buttons_valid),
        .ctrl_present (ctrl_present)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writer model: logs each start pulse and holds busy for one write time.
    initial forever begin
        @(negedge clk);
        if (cmd_en === 1'b1) begin
            if (en_cnt < 64) en_cyc[en_cnt] = cyc;
            en_cnt++;
            last_byte = cmd_byte;
            if (wr_ok) begin
                cmd_busy = 1'b1;
                repeat (WR_CYC) @(negedge clk);
                cmd_busy = 1'b0;
            end
        end
    end

    // Counts clock cycles with buttons_valid high.
    initial forever begin
        @(negedge clk);
        if (buttons_valid === 1'b1) vcnt++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: still running after 90000 cycles, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_busy_fall(input int lim, output bit ok);
        for (int i = 0; i < lim; i++) begin
            if (cmd_busy === 1'b1) break;
            tick(1);
        end
        for (int j = 0; j < lim; j++) begin
            if (cmd_busy === 1'b0) break;
            tick(1);
        end
        ok = (cmd_busy === 1'b0) && (en_cnt > 0);
    endtask

    task automatic wait_en(input int lim, input int n0, output bit ok);
        for (int i = 0; i < lim; i++) begin
            if (en_cnt > n0) break;
            tick(1);
        end
        ok = (en_cnt > n0);
    endtask

    // Controller model: MSB-first bits, 1 = 1us low/3us high, 0 = 3us low/1us high.
    task automatic send_bits(input logic [31:0] w, input int n, input bit stop);
        for (int i = 0; i < n; i++) begin
            data_in = 1'b0;
            tick(w[31-i] ? 10 : 30);
            data_in = 1'b1;
            tick(w[31-i] ? 30 : 10);
        end
        if (stop) begin
            data_in = 1'b0;
            tick(20);
            data_in = 1'b1;
            tick(20);
        end
    endtask

    task automatic test_reset();
        tick(3);
        vectors++; if (cmd_byte !== 8'h01) begin miscompares++; $display("FAIL rst_cmd_byte: got %h expected 01", cmd_byte); end
        vectors++; if (cmd_en !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_en: got %b expected 0", cmd_en); end
        vectors++; if (buttons !== 32'h0) begin miscompares++; $display("FAIL rst_buttons: got %h expected 0", buttons); end
        vectors++; if (buttons_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", buttons_valid); end
        vectors++; if (ctrl_present !== 1'b0) begin miscompares++; $display("FAIL rst_present: got %b expected 0", ctrl_present); end
        rst = 1'b0;
        tick(50);
        vectors++; if (en_cnt !== 0) begin miscompares++; $display("FAIL idle_no_cmd: got %0d pulses expected 0", en_cnt); end
    endtask

    task automatic test_poll();
        bit ok;
        poll_en = 1'b1;
        wait_busy_fall(4000, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL poll_write: got no write expected one"); end
        vectors++; if (en_cnt !== 1) begin miscompares++; $display("FAIL poll_en_count: got %0d expected 1", en_cnt); end
        vectors++; if (last_byte !== 8'h01) begin miscompares++; $display("FAIL poll_cmd_byte: got %h expected 01", last_byte); end
        tick(20);
        send_bits(32'h800000FF, 32, 1'b1);
        tick(5);
        vectors++; if (buttons !== 32'h800000FF) begin miscompares++; $display("FAIL poll_buttons: got %h expected 800000ff", buttons); end
        vectors++; if (vcnt !== 1) begin miscompares++; $display("FAIL poll_valid: got %0d expected 1", vcnt); end
        vectors++; if (ctrl_present !== 1'b1) begin miscompares++; $display("FAIL poll_present: got %b expected 1", ctrl_present); end
    endtask

    task automatic test_no_reply();
        bit ok;
        wait_busy_fall(4000, ok);
        vectors++; if (!ok || en_cnt !== 2) begin miscompares++; $display("FAIL noreply_write: got %0d pulses expected 2", en_cnt); end
        vectors++; if (en_cyc[1] - en_cyc[0] !== PP) begin miscompares++; $display("FAIL noreply_period: got %0d expected %0d", en_cyc[1] - en_cyc[0], PP); end
        tick(RXT - 10);
        vectors++; if (ctrl_present !== 1'b1) begin miscompares++; $display("FAIL noreply_early: got %b expected 1", ctrl_present); end
        tick(20);
        vectors++; if (ctrl_present !== 1'b0) begin miscompares++; $display("FAIL noreply_present: got %b expected 0", ctrl_present); end
        vectors++; if (buttons !== 32'h800000FF) begin miscompares++; $display("FAIL noreply_buttons: got %h expected 800000ff", buttons); end
        vectors++; if (vcnt !== 1) begin miscompares++; $display("FAIL noreply_valid: got %0d expected 1", vcnt); end
    endtask

    task automatic test_partial();
        bit ok;
        wait_busy_fall(4000, ok);
        vectors++; if (!ok || en_cyc[2] - en_cyc[1] !== PP) begin miscompares++; $display("FAIL timeout_period: got %0d expected %0d", en_cyc[2] - en_cyc[1], PP); end
        tick(20);
        send_bits(32'h12345678, 32, 1'b1);
        tick(5);
        vectors++; if (buttons !== 32'h12345678 || ctrl_present !== 1'b1) begin miscompares++; $display("FAIL second_poll: got %h/%b expected 12345678/1", buttons, ctrl_present); end
        wait_busy_fall(4000, ok);
        tick(20);
        send_bits(32'hFFFFFFFF, 17, 1'b0);
        tick(RXT + 50);
        vectors++; if (buttons !== 32'h12345678) begin miscompares++; $display("FAIL partial_buttons: got %h expected 12345678", buttons); end
        vectors++; if (ctrl_present !== 1'b0) begin miscompares++; $display("FAIL partial_present: got %b expected 0", ctrl_present); end
        vectors++; if (vcnt !== 2) begin miscompares++; $display("FAIL partial_valid: got %0d expected 2", vcnt); end
    endtask

    task automatic test_busy_timeout();
        bit ok;
        int n0;
        wait_busy_fall(4000, ok);
        tick(20);
        send_bits(32'hA5A50F0F, 32, 1'b1);
        tick(5);
        vectors++; if (buttons !== 32'hA5A50F0F || ctrl_present !== 1'b1) begin miscompares++; $display("FAIL third_poll: got %h/%b expected a5a50f0f/1", buttons, ctrl_present); end
        wr_ok = 1'b0;
        n0 = en_cnt;
        wait_en(4000, n0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL busy_cmd: got no pulse expected one"); end
        tick(2);
        vectors++; if (ctrl_present !== 1'b1) begin miscompares++; $display("FAIL busy_early: got %b expected 1", ctrl_present); end
        tick(3);
        vectors++; if (ctrl_present !== 1'b0) begin miscompares++; $display("FAIL busy_present: got %b expected 0", ctrl_present); end
        tick(PP - 50);
        vectors++; if (en_cnt !== n0 + 1) begin miscompares++; $display("FAIL busy_no_repulse: got %0d pulses expected %0d", en_cnt, n0 + 1); end
        wr_ok = 1'b1;
        wait_en(200, n0 + 1, ok);
        vectors++; if (!ok || en_cyc[n0 + 1] - en_cyc[n0] !== PP) begin miscompares++; $display("FAIL busy_period: got %0d expected %0d", en_cyc[n0 + 1] - en_cyc[n0], PP); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0;
        int v0;
        wait_busy_fall(4000, ok);
        tick(20);
        send_bits(32'hF0000000, 5, 1'b0);
        data_in = 1'b0;
        tick(10);
        #3 rst = 1'b1;
        #1;
        vectors++; if (buttons !== 32'h0 || ctrl_present !== 1'b0 || buttons_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_outs: got %h/%b/%b expected 0/0/0", buttons, ctrl_present, buttons_valid); end
        vectors++; if (cmd_byte !== 8'h01 || cmd_en !== 1'b0) begin miscompares++; $display("FAIL async_rst_cmd: got %h/%b expected 01/0", cmd_byte, cmd_en); end
        data_in = 1'b1;
        tick(3);
        rst = 1'b0;
        n0 = en_cnt;
        v0 = vcnt;
        wait_en(50, n0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL post_rst_cmd: got no pulse expected one"); end
        wait_busy_fall(4000, ok);
        poll_en = 1'b0;
        tick(20);
        send_bits(32'h00008001, 32, 1'b1);
        tick(5);
        vectors++; if (buttons !== 32'h00008001) begin miscompares++; $display("FAIL post_rst_buttons: got %h expected 00008001", buttons); end
        vectors++; if (ctrl_present !== 1'b1 || vcnt !== v0 + 1) begin miscompares++; $display("FAIL post_rst_status: got %b/%0d expected 1/%0d", ctrl_present, vcnt, v0 + 1); end
        tick(PP + 100);
        vectors++; if (en_cnt !== n0 + 1) begin miscompares++; $display("FAIL stop_polling: got %0d pulses expected %0d", en_cnt, n0 + 1); end
    endtask

`ifdef N64_STATUS_PROBE_EN
    task automatic test_probe();
        bit ok;
        int n0;
        poll_en = 1'b1;
        wait_busy_fall(4000, ok);
        vectors++; if (!ok || last_byte !== 8'h00) begin miscompares++; $display("FAIL probe_first: got %h expected 00", last_byte); end
        tick(20);
        send_bits({24'h050002, 8'h00}, 24, 1'b1);
        tick(5);
        vectors++; if (en_cnt !== 2 || last_byte !== 8'h01) begin miscompares++; $display("FAIL probe_then_poll: got %0d/%h expected 2/01", en_cnt, last_byte); end
        vectors++; if (ctrl_present !== 1'b1 || vcnt !== 0) begin miscompares++; $display("FAIL probe_ok: got %b/%0d expected 1/0", ctrl_present, vcnt); end
        n0 = en_cnt;
        wait_en(4000, n0, ok);
        vectors++; if (!ok || last_byte !== 8'h00) begin miscompares++; $display("FAIL reprobe: got %h expected 00", last_byte); end
        wait_busy_fall(4000, ok);
        tick(20);
        send_bits({24'h010000, 8'h00}, 24, 1'b1);
        tick(5);
        vectors++; if (ctrl_present !== 1'b0 || vcnt !== 0 || buttons !== 32'h0) begin miscompares++; $display("FAIL probe_bad: got %b/%0d/%h expected 0/0/0", ctrl_present, vcnt, buttons); end
        tick(PP / 2);
        vectors++; if (en_cnt !== n0 + 1) begin miscompares++; $display("FAIL probe_no_poll: got %0d pulses expected %0d", en_cnt, n0 + 1); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef N64_STATUS_PROBE_EN
        test_probe();
`else
        test_poll();
        test_no_reply();
        test_partial();
        test_busy_timeout();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
